// File: rtl/multi_port_regfile.sv
// Multi-port register file with optional write-to-read bypass
// and a per-register busy scoreboard for the pipelined core.
module multi_port_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic              rsv_ok;

  // Gating with rst keeps reset-cycle writes out of both state and bypass.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wa[w]    = wr_addr[w*ADDR_W +: ADDR_W];
    assign wd[w]    = wr_data[w*DATA_W +: DATA_W];
    assign wr_ok[w] = rst && wr_en[w] &&
                      !((ZERO_REG != 0) && (wa[w] == '0));
  end

  assign rsv_ok = rsv_en &&
                  !((ZERO_REG != 0) && (rsv_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_ok[w]) regs[wa[w]] <= wd[w];
    end
  end

  // Later assignments win: write clear < reserve set < flush.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_ok[w]) busy_nxt[wa[w]] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    always_comb begin
      a = rd_addr[p*ADDR_W +: ADDR_W];
      d = regs[a];
      b = busy[a];
      for (int w = 0; w < NUM_WR; w++) begin
        if ((BYPASS != 0) && wr_ok[w] && (wa[w] == a)) begin
          d = wd[w];
          b = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = d;
    assign rd_busy[p]                  = b;
  end

endmodule

// File: tb/tb_multi_port_regfile.sv
// Directed bench for multi_port_regfile: reset, r0, bypass,
// dual write, scoreboard and flush behaviour.
module tb_multi_port_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [63:0] rd_data_nb;
  logic [1:0]  rd_busy_nb;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_port_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush)
  );

  multi_port_regfile #(.BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_nb),
    .rd_busy  (rd_busy_nb),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [31:0] d);
    wr_en[p]           = 1'b1;
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    rst      = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rd_addr = {5'd1, 5'd0};
    #1;
    check("rst_d0", rd_data[31:0], 32'h0);
    check("rst_d1", rd_data[63:32], 32'h0);
    check("rst_b", {30'd0, rd_busy}, 32'h0);

    // T1: write+reserve r5, then async reset mid-operation
    wr(0, 5'd5, 32'hDEADBEEF);
    rsv(5'd5);
    tick();
    rd_addr = {5'd0, 5'd5};
    #1;
    check("t1_wr", rd_data[31:0], 32'hDEADBEEF);
    check("t1_busy", {31'd0, rd_busy[0]}, 32'h1);
    wr(0, 5'd5, 32'h77);
    rsv(5'd6);
    rst = 1'b0;
    #1;
    check("t1_rst_d", rd_data[31:0], 32'h0);
    check("t1_rst_b", {31'd0, rd_busy[0]}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    rd_addr = {5'd6, 5'd5};
    #1;
    check("t1_after_d", rd_data[31:0], 32'h0);
    check("t1_after_b", {30'd0, rd_busy}, 32'h0);

    // T2: r0 ignores writes and reservations
    wr(0, 5'd0, 32'h1234);
    rsv(5'd0);
    rd_addr = {5'd0, 5'd0};
    #1;
    check("t2_same_d", rd_data[31:0], 32'h0);
    tick();
    check("t2_d", rd_data[31:0], 32'h0);
    check("t2_b", {31'd0, rd_busy[0]}, 32'h0);

    // T3: bypass vs no bypass
    wr(1, 5'd7, 32'h11);
    tick();
    wr(0, 5'd7, 32'h22);
    rd_addr = {5'd0, 5'd7};
    #1;
    check("t3_byp", rd_data[31:0], 32'h22);
    check("t3_nobyp", rd_data_nb[31:0], 32'h11);
    tick();
    check("t3_byp_n1", rd_data[31:0], 32'h22);
    check("t3_nobyp_n1", rd_data_nb[31:0], 32'h22);

    // T4: dual write same address, port 1 wins
    rsv(5'd3);
    tick();
    rd_addr = {5'd3, 5'd0};
    #1;
    check("t4_busy_set", {31'd0, rd_busy[1]}, 32'h1);
    wr(0, 5'd3, 32'hAAAA);
    wr(1, 5'd3, 32'h5555);
    #1;
    check("t4_byp_d", rd_data[63:32], 32'h5555);
    check("t4_byp_b", {31'd0, rd_busy[1]}, 32'h0);
    check("t4_nb_b", {31'd0, rd_busy_nb[1]}, 32'h1);
    tick();
    check("t4_d", rd_data[63:32], 32'h5555);
    check("t4_nb_d", rd_data_nb[63:32], 32'h5555);
    check("t4_b", {31'd0, rd_busy[1]}, 32'h0);

    // T5: scoreboard
    rsv(5'd9);
    tick();
    rd_addr = {5'd0, 5'd9};
    #1;
    check("t5_rsv_b", {31'd0, rd_busy[0]}, 32'h1);
    wr(0, 5'd9, 32'h9);
    tick();
    check("t5_wr_b", {31'd0, rd_busy[0]}, 32'h0);
    check("t5_wr_d", rd_data[31:0], 32'h9);
    wr(1, 5'd9, 32'h9);
    rsv(5'd9);
    tick();
    check("t5_rw_d", rd_data[31:0], 32'h9);
    check("t5_rw_b", {31'd0, rd_busy[0]}, 32'h1);

    // T6: flush clears busy only, same-cycle write commits
    wr(0, 5'd1, 32'h101);
    wr(1, 5'd2, 32'h202);
    tick();
    rsv(5'd1);
    tick();
    rsv(5'd2);
    tick();
    rsv(5'd4);
    tick();
    rd_addr = {5'd2, 5'd1};
    #1;
    check("t6_pre_b", {30'd0, rd_busy}, 32'h3);
    rd_addr = {5'd9, 5'd4};
    #1;
    check("t6_pre_b4", {30'd0, rd_busy}, 32'h3);
    flush = 1'b1;
    wr(0, 5'd4, 32'h44);
    tick();
    check("t6_b49", {30'd0, rd_busy}, 32'h0);
    check("t6_d4", rd_data[31:0], 32'h44);
    check("t6_d9", rd_data[63:32], 32'h9);
    rd_addr = {5'd2, 5'd1};
    #1;
    check("t6_b12", {30'd0, rd_busy}, 32'h0);
    check("t6_d1", rd_data[31:0], 32'h101);
    check("t6_d2", rd_data[63:32], 32'h202);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
